// File: rtl/alu_issue_ctrl.sv
// Execute-stage issue controller for the combinational vector ALU.
// Holds the ALU inputs stable for one or DIV_LAT cycles, then hands the result to writeback.
//
// state | meaning
// IDLE  | ready for a new instruction; illegal encodings are rejected here
// EXEC  | ALU inputs held from the holding registers while the counter runs down
// WB    | result presented to writeback until wb_ready
module alu_issue_ctrl #(
  parameter int          DIV_LAT  = 4,
  parameter logic [0:5]  RTYPE_OP = 6'b101010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [0:31] instr,
  input  logic [0:63] rA_64bit_val,
  input  logic [0:63] rB_64bit_val,
  output logic [0:63] alu_rA,
  output logic [0:63] alu_rB,
  output logic [0:5]  alu_R_ins,
  output logic [0:5]  alu_Op_code,
  output logic [0:1]  alu_WW,
  input  logic [0:63] ALU_out,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [0:63] wb_data,
  output logic [0:4]  wb_rD,
  output logic        illegal_op
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic [0:4] rd_q;

  logic [0:5] op_in;
  logic [0:5] func_in;
  logic [0:4] rd_in;
  logic [0:1] ww_in;
  logic       legal;
  logic       long_op;
  logic       unused_fields;

  assign op_in   = instr[0:5];
  assign rd_in   = instr[6:10];
  assign ww_in   = instr[24:25];
  assign func_in = instr[26:31];
  // Source register fields are resolved upstream; only the operand values matter here.
  assign unused_fields = ^instr[11:23];

  assign legal   = (op_in == RTYPE_OP) && (func_in >= 6'b000001) && (func_in <= 6'b010010);
  assign long_op = (func_in == 6'b001110) || (func_in == 6'b001111) || (func_in == 6'b010010);

  assign in_ready = (state == IDLE);
  assign wb_valid = (state == WB);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid && legal) state_nxt = EXEC;
      EXEC:    if (cnt == 4'd0)       state_nxt = WB;
      WB:      if (wb_ready)          state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  // The alu_* outputs are themselves the holding registers, so they only
  // change on a legal accept and stay put through EXEC and afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_rA      <= '0;
      alu_rB      <= '0;
      alu_R_ins   <= '0;
      alu_Op_code <= '0;
      alu_WW      <= '0;
      rd_q        <= '0;
      cnt         <= '0;
      wb_data     <= '0;
      wb_rD       <= '0;
      illegal_op  <= 1'b0;
    end else begin
      illegal_op <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (legal) begin
              alu_rA      <= rA_64bit_val;
              alu_rB      <= rB_64bit_val;
              alu_R_ins   <= func_in;
              alu_Op_code <= op_in;
              alu_WW      <= ww_in;
              rd_q        <= rd_in;
              cnt         <= long_op ? 4'(DIV_LAT - 1) : 4'd0;
            end else begin
              illegal_op <= 1'b1;
            end
          end
        end
        EXEC: begin
          if (cnt == 4'd0) begin
            wb_data <= ALU_out;
            wb_rD   <= rd_q;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural lane-ALU hooked to its alu_* outputs.
module tb_alu_issue_ctrl;

  localparam int         DIV_LAT = 4;
  localparam logic [5:0] RTYPE   = 6'b101010;
  localparam logic [5:0] F_AND = 6'b000001, F_OR = 6'b000010, F_ADD = 6'b000100,
                         F_SUB = 6'b000101, F_DIV = 6'b001110, F_MOD = 6'b001111,
                         F_SQRT = 6'b010010;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [0:31] instr = '0;
  logic [0:63] rA_v = '0, rB_v = '0;
  logic [0:63] alu_rA, alu_rB, ALU_out, wb_data;
  logic [0:5]  alu_R_ins, alu_Op_code;
  logic [0:1]  alu_WW;
  logic        wb_valid, illegal_op;
  logic        wb_ready = 1'b1;
  logic [0:4]  wb_rD;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] q_data[$];
  logic [4:0]  q_rd[$];

  alu_issue_ctrl #(.DIV_LAT(DIV_LAT), .RTYPE_OP(RTYPE)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .rA_64bit_val(rA_v), .rB_64bit_val(rB_v), .alu_rA(alu_rA), .alu_rB(alu_rB),
    .alu_R_ins(alu_R_ins), .alu_Op_code(alu_Op_code), .alu_WW(alu_WW), .ALU_out(ALU_out),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rD(wb_rD),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] alu_model(input logic [63:0] a, b, input logic [5:0] f,
                                            input logic [1:0] ww);
    int lw;
    logic [63:0] mask, x, y, z, r;
    lw   = 8 << ww;
    mask = (lw == 64) ? '1 : ((64'd1 << lw) - 64'd1);
    r    = '0;
    for (int l = 0; l < 64 / lw; l++) begin
      x = (a >> (l * lw)) & mask;
      y = (b >> (l * lw)) & mask;
      case (f)
        F_AND:   z = x & y;
        F_OR:    z = x | y;
        F_ADD:   z = x + y;
        F_SUB:   z = x - y;
        F_DIV:   z = (y == 0) ? 64'd0 : x / y;
        F_MOD:   z = (y == 0) ? 64'd0 : x % y;
        F_SQRT:  z = x;
        default: z = '0;
      endcase
      r = r | ((z & mask) << (l * lw));
    end
    return r;
  endfunction

  always_comb ALU_out = alu_model(alu_rA, alu_rB, alu_R_ins, alu_WW);

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                     input logic [1:0] ww, input logic [5:0] f);
    return {op, rd, 5'd1, 5'd2, 3'd0, ww, f};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && wb_valid && wb_ready) begin
      if (q_data.size() == 0) chk("sb_unexpected_wb", 64'd1, 64'd0);
      else begin
        chk("sb_wb_data", wb_data, q_data.pop_front());
        chk("sb_wb_rD", 64'(wb_rD), 64'(q_rd.pop_front()));
      end
    end
  end

  task automatic push_exp(input logic [31:0] ins, input logic [63:0] a, b);
    q_data.push_back(alu_model(a, b, ins[5:0], ins[7:6]));
    q_rd.push_back(ins[25:21]);
  endtask

  task automatic wait_wb(input logic [31:0] ins, input logic [63:0] a, b, output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (wb_valid) begin
        n = i;
        break;
      end
      chk("exec_rA", alu_rA, a);
      chk("exec_rB", alu_rB, b);
      chk("exec_R_ins", 64'(alu_R_ins), 64'(ins[5:0]));
      chk("exec_Op_code", 64'(alu_Op_code), 64'(ins[31:26]));
      chk("exec_WW", 64'(alu_WW), 64'(ins[7:6]));
      chk("exec_in_ready", 64'(in_ready), 64'd0);
    end
    if (n == 0) chk("wb_timeout", 64'd0, 64'd1);
  endtask

  task automatic issue(input logic [31:0] ins, input logic [63:0] a, b, input int lat,
                       input logic [63:0] exp_data);
    int n;
    @(posedge clk); #1;
    instr = ins; rA_v = a; rB_v = b; in_valid = 1'b1;
    push_exp(ins, a, b);
    @(negedge clk);
    chk("accept_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_wb(ins, a, b, n);
    chk("latency", 64'(n), 64'(lat));
    chk("wb_data_ref", wb_data, exp_data);
    chk("wb_rD_ref", 64'(wb_rD), 64'(ins[25:21]));
  endtask

  task automatic illegal(input logic [31:0] ins, input logic [63:0] prev_a);
    @(posedge clk); #1;
    instr = ins; rA_v = 64'hDEAD; rB_v = 64'hBEEF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("ill_pulse", 64'(illegal_op), 64'd1);
    chk("ill_in_ready", 64'(in_ready), 64'd1);
    chk("ill_no_wb", 64'(wb_valid), 64'd0);
    chk("ill_alu_kept", alu_rA, prev_a);
    @(negedge clk);
    chk("ill_pulse_end", 64'(illegal_op), 64'd0);
    chk("ill_no_wb2", 64'(wb_valid), 64'd0);
  endtask

  initial begin
    int n;
    logic [31:0] i_mod, i_or;
    int seen_wb;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_illegal", 64'(illegal_op), 64'd0);
    chk("rst_alu_rA", alu_rA, 64'd0);
    chk("rst_alu_R_ins", 64'(alu_R_ins), 64'd0);
    chk("rst_wb_data", wb_data, 64'd0);

    issue(32'hA8611081, 64'd15, 64'd14, 2, 64'd14);
    issue(mk(RTYPE, 5'd7, 2'b11, F_ADD), 64'hFFFFFFFF_FFFFFFFF, 64'h00000000_11111111,
          2, 64'h00000000_11111110);
    issue(mk(RTYPE, 5'd8, 2'b10, F_SUB), 64'hFFFFFFFF_FFFFFFFF, 64'h0F0F0F0F_11111111,
          2, 64'hF0F0F0F0_EEEEEEEE);
    issue(mk(RTYPE, 5'd9, 2'b00, F_DIV), 64'h64503C28_140A08FF, 64'h0A050304_02050210,
          DIV_LAT + 1, 64'h0A10140A_0A02040F);

    // Backpressure: VMOD result must hold while a second instruction waits upstream.
    i_mod = mk(RTYPE, 5'd10, 2'b11, F_MOD);
    i_or  = mk(RTYPE, 5'd11, 2'b11, F_OR);
    @(posedge clk); #1;
    wb_ready = 1'b0;
    instr = i_mod; rA_v = 64'd102; rB_v = 64'd10; in_valid = 1'b1;
    push_exp(i_mod, 64'd102, 64'd10);
    @(posedge clk); #1;
    instr = i_or; rA_v = 64'd5; rB_v = 64'd48;
    wait_wb(i_mod, 64'd102, 64'd10, n);
    chk("bp_latency", 64'(n), 64'(DIV_LAT + 1));
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      chk("bp_wb_valid", 64'(wb_valid), 64'd1);
      chk("bp_wb_data", wb_data, 64'd2);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    wb_ready = 1'b1;
    push_exp(i_or, 64'd5, 64'd48);
    @(negedge clk);
    chk("bp_no_accept", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("bp_idle_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_wb(i_or, 64'd5, 64'd48, n);
    chk("bp_second_data", wb_data, 64'd53);

    // Reset during the second EXEC cycle of a long op.
    @(posedge clk); #1;
    instr = mk(RTYPE, 5'd12, 2'b11, F_SQRT); rA_v = 64'd81; rB_v = 64'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_wb_valid", 64'(wb_valid), 64'd0);
    chk("abort_alu_rA", alu_rA, 64'd0);
    chk("abort_alu_rB", alu_rB, 64'd0);
    chk("abort_alu_R_ins", 64'(alu_R_ins), 64'd0);
    chk("abort_alu_Op_code", 64'(alu_Op_code), 64'd0);
    seen_wb = 0;
    repeat (8) begin
      @(negedge clk);
      if (wb_valid) seen_wb++;
    end
    chk("abort_no_wb", 64'(seen_wb), 64'd0);
    issue(mk(RTYPE, 5'd13, 2'b11, F_OR), 64'd15, 64'd14, 2, 64'd15);

    illegal(mk(6'b000000, 5'd4, 2'b11, F_AND), 64'd15);
    illegal(mk(RTYPE, 5'd4, 2'b11, 6'b010011), 64'd15);

    repeat (4) @(negedge clk);
    chk("sb_drained", 64'(q_data.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
